// File: rtl/debug_dump_pkg.sv
// Shared definitions for the debug dump engine: FSM states, DDR3 debug window base, channel limit.
// The CSUM state exists only when DEBUG_DUMP_CHECKSUM_EN is defined.
package debug_dump_pkg;

    localparam logic [27:0] DDR3_DEBUG_BASE = 28'h1400000;
    localparam int          MAX_CHANNELS    = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_LATCH    = 3'd2,
        ST_WAIT_RDY = 3'd3,
        ST_WRITE    = 3'd4,
        ST_NEXT     = 3'd5,
        ST_DONE     = 3'd6
`ifdef DEBUG_DUMP_CHECKSUM_EN
        ,
        ST_CSUM     = 3'd7
`endif
    } dump_state_t;

    // Byte address of (channel, index) inside the debug area; 28-bit wrap is intentional.
    function automatic logic [27:0] win_addr(input logic [27:0] base,
                                             input logic [3:0]  chan,
                                             input logic [15:0] idx,
                                             input int          win_w);
        win_addr = base + ({24'd0, chan} << win_w) + {12'd0, idx};
    endfunction

endpackage

// File: rtl/debug_dump_addr_gen.sv
// Channel/index counters of the debug dump engine and the registered DDR3 byte address.
// Supports the checksum index jump used when DEBUG_DUMP_CHECKSUM_EN is defined.
module debug_dump_addr_gen
    import debug_dump_pkg::*;
#(
    parameter int          WIN_W     = 8,
    parameter logic [27:0] BASE_ADDR = DDR3_DEBUG_BASE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_idx_i,
    input  logic             inc_chan_i,
    input  logic             set_idx_i,
    input  logic [WIN_W-1:0] idx_val_i,
    output logic [3:0]       chan_o,
    output logic [WIN_W-1:0] idx_o,
    output logic [27:0]      addr_o
);

    logic [3:0]       chan_q, chan_d;
    logic [WIN_W-1:0] idx_q, idx_d;
    logic [27:0]      addr_q, addr_d;

    // Next counter values; the address is precomputed so it is valid in the FETCH cycle.
    always_comb begin
        chan_d = chan_q;
        idx_d  = idx_q;
        if (clr_i) begin
            chan_d = 4'd0;
            idx_d  = '0;
        end else if (inc_chan_i) begin
            chan_d = chan_q + 4'd1;
            idx_d  = '0;
        end else if (inc_idx_i) begin
            idx_d = idx_q + WIN_W'(1);
        end else if (set_idx_i) begin
            idx_d = idx_val_i;
        end else begin
            chan_d = chan_q;
            idx_d  = idx_q;
        end
        addr_d = win_addr(BASE_ADDR, chan_d, 16'(idx_d), WIN_W);
    end

    // Counter and address registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chan_q <= 4'd0;
            idx_q  <= '0;
            addr_q <= BASE_ADDR;
        end else begin
            chan_q <= chan_d;
            idx_q  <= idx_d;
            addr_q <= addr_d;
        end
    end

    assign chan_o = chan_q;
    assign idx_o  = idx_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/debug_dump.sv
// Debug dump engine: copies each source channel window byte-by-byte into DDR3.
// Define DEBUG_DUMP_CHECKSUM_EN to append a modulo-256 checksum byte per non-empty channel.
module debug_dump
    import debug_dump_pkg::*;
#(
    parameter int          CHANNELS   = 8,
    parameter int          WIN_W      = 8,
    parameter logic [27:0] BASE_ADDR  = DDR3_DEBUG_BASE,
    parameter int          AUTO_START = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [CHANNELS*WIN_W-1:0] chan_len,
    output logic [3:0]                src_sel,
    output logic [WIN_W-1:0]          src_addr,
    input  logic [7:0]                src_data,
    output logic                      busy,
    output logic                      done,
    output logic [27:0]               ddr3_addr,
    output logic [7:0]                ddr3_din,
    output logic                      ddr3_upload,
    output logic                      ddr3_wr,
    input  logic                      ddr3_ready
);

    dump_state_t      state_q;
    logic             busy_q, done_q, upload_q, wr_q, auto_q;
    logic [7:0]       din_q;
    logic [WIN_W-1:0] len_q;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [7:0]       sum_q;
    logic             csum_ph_q;
`endif

    logic [3:0]       chan_s;
    logic [WIN_W-1:0] idx_s, cur_len_s;
    logic             go_s, more_idx_s, last_idx_s, last_chan_s;
    logic             clr_s, inc_idx_s, inc_chan_s, set_idx_s;

    assign cur_len_s   = chan_len[int'(chan_s)*WIN_W +: WIN_W];
    assign go_s        = (state_q == ST_IDLE) && (start || auto_q);
    assign more_idx_s  = (len_q != '0) && (idx_s < (len_q - WIN_W'(1)));
    assign last_idx_s  = (idx_s == (len_q - WIN_W'(1)));
    assign last_chan_s = (chan_s == 4'(CHANNELS - 1));

    // Counter commands decoded from the current state.
    always_comb begin
        clr_s      = go_s;
        inc_idx_s  = (state_q == ST_NEXT) && more_idx_s;
        inc_chan_s = (state_q == ST_NEXT) && !more_idx_s && !last_chan_s;
`ifdef DEBUG_DUMP_CHECKSUM_EN
        set_idx_s  = (state_q == ST_WRITE) && !csum_ph_q && last_idx_s;
`else
        set_idx_s  = 1'b0;
`endif
    end

    debug_dump_addr_gen #(
        .WIN_W     (WIN_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (clr_s),
        .inc_idx_i  (inc_idx_s),
        .inc_chan_i (inc_chan_s),
        .set_idx_i  (set_idx_s),
        .idx_val_i  (len_q),
        .chan_o     (chan_s),
        .idx_o      (idx_s),
        .addr_o     (ddr3_addr)
    );

    // Dump sequencer with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            upload_q <= 1'b0;
            wr_q     <= 1'b0;
            din_q    <= 8'd0;
            len_q    <= '0;
            auto_q   <= (AUTO_START != 0);
`ifdef DEBUG_DUMP_CHECKSUM_EN
            sum_q     <= 8'd0;
            csum_ph_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (go_s) begin
                        busy_q   <= 1'b1;
                        upload_q <= 1'b1;
                        auto_q   <= 1'b0;
                        state_q  <= ST_FETCH;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                        sum_q     <= 8'd0;
                        csum_ph_q <= 1'b0;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    len_q <= cur_len_s;
                    if (cur_len_s == '0) begin
                        state_q <= ST_NEXT;
                    end else begin
                        state_q <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    din_q <= src_data;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                    sum_q <= sum_q + src_data;
`endif
                    if (ddr3_ready) begin
                        wr_q    <= 1'b1;
                        state_q <= ST_WRITE;
                    end else begin
                        state_q <= ST_WAIT_RDY;
                    end
                end
                ST_WAIT_RDY: begin
                    if (ddr3_ready) begin
                        wr_q    <= 1'b1;
                        state_q <= ST_WRITE;
                    end else begin
                        state_q <= ST_WAIT_RDY;
                    end
                end
                ST_WRITE: begin
                    wr_q <= 1'b0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                    if (set_idx_s) begin
                        din_q     <= sum_q;
                        csum_ph_q <= 1'b1;
                        state_q   <= ST_CSUM;
                    end else begin
                        state_q <= ST_NEXT;
                    end
`else
                    state_q <= ST_NEXT;
`endif
                end
`ifdef DEBUG_DUMP_CHECKSUM_EN
                ST_CSUM: begin
                    if (ddr3_ready) begin
                        wr_q    <= 1'b1;
                        state_q <= ST_WRITE;
                    end else begin
                        state_q <= ST_CSUM;
                    end
                end
`endif
                ST_NEXT: begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                    csum_ph_q <= 1'b0;
                    if (inc_chan_s) begin
                        sum_q <= 8'd0;
                    end else begin
                        sum_q <= sum_q;
                    end
`endif
                    if (inc_idx_s || inc_chan_s) begin
                        state_q <= ST_FETCH;
                    end else begin
                        busy_q   <= 1'b0;
                        upload_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q   <= 1'b0;
                    upload_q <= 1'b0;
                    wr_q     <= 1'b0;
                    done_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign src_sel     = chan_s;
    assign src_addr    = idx_s;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ddr3_din    = din_q;
    assign ddr3_upload = upload_q;
    assign ddr3_wr     = wr_q;

endmodule

// File: doc/debug_dump.md
DEBUG_DUMP -- requirements
Module: debug_dump

Interface
REQ-001 Parameter CHANNELS, default 8: number of source channels dumped, range 1..16.
REQ-002 Parameter WIN_W, default 8: log2 of bytes per channel window in DDR3.
REQ-003 Parameter BASE_ADDR, default 28'h1400000: DDR3 byte address of channel 0 window.
REQ-004 Parameter AUTO_START, default 1: 1 = start one dump automatically on reset release.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  single-cycle dump request.
REQ-008 chan_len  in  CHANNELS*WIN_W  per-channel byte count; channel c occupies bits [c*WIN_W +: WIN_W].
REQ-009 src_sel  out  4  channel being read.
REQ-010 src_addr  out  WIN_W  byte index within channel.
REQ-011 src_data  in  8  source byte, valid exactly one clk after src_sel/src_addr change.
REQ-012 busy  out  1  dump in progress.
REQ-013 done  out  1  one-cycle pulse when a dump completes.
REQ-014 ddr3_addr  out  28  BASE_ADDR + (channel << WIN_W) + byte index.
REQ-015 ddr3_din  out  8  write data.
REQ-016 ddr3_upload  out  1  DDR3 bus request, held for the whole dump.
REQ-017 ddr3_wr  out  1  one-cycle write strobe.
REQ-018 ddr3_ready  in  1  DDR3 can accept a write.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, LATCH, WAIT_RDY, WRITE, NEXT, DONE.
REQ-020 IDLE: on start, or on the first cycle after reset release when AUTO_START=1, load channel=0, index=0, set busy, then go to FETCH.
REQ-021 FETCH: drive src_sel/src_addr and assert ddr3_upload. If chan_len of the current channel is 0, skip to NEXT without writing.
REQ-022 LATCH (one clk after FETCH): capture src_data into ddr3_din.
REQ-023 WAIT_RDY: hold every output until ddr3_ready=1, then go to WRITE. There is no timeout.
REQ-024 WRITE: ddr3_wr=1 for exactly one clk, with ddr3_addr and ddr3_din stable from LATCH through WRITE.
REQ-025 NEXT: if index < chan_len-1, increment index and go to FETCH. Otherwise, if channel < CHANNELS-1, increment channel, clear index and go to FETCH. Otherwise go to DONE.
REQ-026 DONE: deassert ddr3_upload and busy, pulse done for one clk, return to IDLE.
REQ-027 Minimum cost with ddr3_ready held high: 4 clk per byte.
REQ-028 start while busy SHALL be ignored and SHALL NOT be queued.
REQ-029 Address arithmetic is 28-bit with no overflow check; the integrator keeps BASE_ADDR + CHANNELS<<WIN_W below 2^28.
REQ-030 chan_len is sampled at each FETCH; a change mid-dump affects only bytes not yet fetched.
REQ-031 ddr3_wr SHALL never be asserted while ddr3_upload=0.

Reset
REQ-032 Reset SHALL force state=IDLE, channel=0, index=0, busy=0, done=0, ddr3_upload=0, ddr3_wr=0, ddr3_din=0, src_sel=0, src_addr=0, immediately and asynchronously, including mid-write.
REQ-033 A dump interrupted by reset is abandoned; with AUTO_START=1 a fresh dump begins after release.

Configuration
REQ-034 Macro DEBUG_DUMP_CHECKSUM_EN defined: after the last byte of each channel with chan_len>0, write one extra byte at index chan_len. Its value is the 8-bit modulo-256 sum of that channel's bytes, using the same WAIT_RDY/WRITE handshake (state CSUM before NEXT).
REQ-035 Macro undefined: no checksum byte, no CSUM state, no accumulator logic.

Structure
REQ-036 The FSM state enum, the DDR3 debug base constant and the maximum CHANNELS constant SHALL live in the shared MSX package.
REQ-037 One sub-module, debug_dump_addr_gen, holds the channel/index counters and ddr3_addr computation. The FSM stays in debug_dump.

Verification
REQ-038 CHANNELS=2, WIN_W=4, chan_len={3,2}, ready=1, source byte = {sel,addr} -> writes 0x00,0x01,0x02 at 0x1400000..2, then 0x10,0x11 at 0x1400010..11; done after 20 clk of writing.
REQ-039 ready held low 50 clk during byte 1 -> ddr3_wr stays 0, addr/din stable, dump resumes with no lost or duplicate byte.
REQ-040 chan_len={0,2} -> channel 0 produces no writes, channel 1 writes 2 bytes, one done pulse.
REQ-041 start pulsed while busy -> exactly one done pulse and write count = sum of chan_len.
REQ-042 Reset asserted during WRITE -> ddr3_wr and ddr3_upload drop in the same cycle; with AUTO_START=1 the dump restarts at 0x1400000.
REQ-043 With DEBUG_DUMP_CHECKSUM_EN, chan_len={3}, bytes 0x10,0x20,0xF0 -> 4th write at 0x1400003 equals 0x20.
